kamus_lsu: RTL

//  Load/store unit of the MEM stage; consumes the EX-MEM interface (operation, effective address, rs2 data, rd).

---
 rtl/kamus_pkg.sv | 76 +++++++
 rtl/kamus_lsu_align.sv | 56 +++++
 rtl/kamus_lsu.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/kamus_pkg.sv
// Shared operation encoding (common with decoder/EX) plus LSU state, access-size types and decode helpers.
package kamus_pkg;

  typedef enum logic [5:0] {
    OP_NOP = 6'd0,
    OP_ADD = 6'd1,
    OP_SUB = 6'd2,
    OP_AND = 6'd3,
    OP_OR  = 6'd4,
    OP_XOR = 6'd5,
    OP_LB  = 6'd16,
    OP_LH  = 6'd17,
    OP_LW  = 6'd18,
    OP_LBU = 6'd19,
    OP_LHU = 6'd20,
    OP_SB  = 6'd24,
    OP_SH  = 6'd25,
    OP_SW  = 6'd26
  } operation_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } lsu_size_e;

  function automatic logic is_load(operation_e op);
    logic r;
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: r = 1'b1;
      default:                             r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_store(operation_e op);
    logic r;
    case (op)
      OP_SB, OP_SH, OP_SW: r = 1'b1;
      default:             r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic lsu_size_e access_size(operation_e op);
    lsu_size_e r;
    case (op)
      OP_LB, OP_LBU, OP_SB: r = BYTE;
      OP_LH, OP_LHU, OP_SH: r = HALF;
      default:              r = WORD;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(operation_e op, logic [1:0] addr_lo);
    logic r;
    r = 1'b0;
    if (is_load(op) || is_store(op)) begin
      case (access_size(op))
        HALF:    r = addr_lo[0];
        WORD:    r = |addr_lo;
        default: r = 1'b0;
      endcase
    end else begin
      r = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/kamus_lsu_align.sv
// Combinational byte-lane logic: store byte enables / lane replication and load extract with sign/zero extension.
module kamus_lsu_align
  import kamus_pkg::*;
(
  input  operation_e  i_st_op,
  input  logic [1:0]  i_st_addr_lo,
  input  logic [31:0] i_st_wdata,
  input  operation_e  i_ld_op,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_ld_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_byte_sh;
  logic [31:0] w_half_sh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_st_wdata;
    case (access_size(i_st_op))
      BYTE: begin
        o_be    = 4'b0001 << i_st_addr_lo;
        o_wdata = {4{i_st_wdata[7:0]}};
      end
      HALF: begin
        o_be    = 4'b0011 << i_st_addr_lo;
        o_wdata = {2{i_st_wdata[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_st_wdata;
      end
    endcase
  end

  assign w_byte_sh = i_ld_rdata >> {i_ld_addr_lo, 3'b000};
  assign w_half_sh = i_ld_rdata >> {i_ld_addr_lo[1], 4'b0000};
  assign w_byte    = w_byte_sh[7:0];
  assign w_half    = w_half_sh[15:0];

  always_comb begin
    o_ld_data = i_ld_rdata;
    case (i_ld_op)
      OP_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_ld_data = {24'h000000, w_byte};
      OP_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_ld_data = {16'h0000, w_half};
      default: o_ld_data = i_ld_rdata;
    endcase
  end

endmodule

// File: rtl/kamus_lsu.sv
// MEM-stage load/store unit: IDLE->REQ->RSP handshake with L1D, pipeline stall, misalign and bus-timeout exceptions.
module kamus_lsu
  import kamus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TO_W           = 9
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [5:0]  operation_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_addr_i,
  output logic        stall_o,
  output logic        l1d_req_o,
  output logic        l1d_we_o,
  output logic [31:0] l1d_addr_o,
  output logic [3:0]  l1d_be_o,
  output logic [31:0] l1d_wdata_o,
  input  logic        l1d_gnt_i,
  input  logic        l1d_rvalid_i,
  input  logic [31:0] l1d_rdata_i,
  output logic        wb_valid_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic        exc_misalign_o,
  output logic        exc_bus_err_o
);

  operation_e      w_op;
  logic            w_is_mem;
  logic            w_misalign;
  logic            w_retiring;
  logic            w_start;
  lsu_state_e      r_state;
  lsu_state_e      w_state_nxt;
  logic            w_gnt_acc;
  logic            w_done;
  logic            w_timeout;
  logic            w_cnt_expired;
  logic [TO_W-1:0] r_cnt;

  operation_e      r_op;
  logic [1:0]      r_addr_lo;
  logic [4:0]      r_rd;
  logic            r_req;
  logic            r_we;
  logic [31:0]     r_addr;
  logic [3:0]      r_be;
  logic [31:0]     r_wdata;
  logic            r_wb_valid;
  logic [31:0]     r_wb_data;
  logic            r_bus_err;

  logic [3:0]      w_be;
  logic [31:0]     w_wdata;
  logic [31:0]     w_ld_data;

  assign w_op       = operation_e'(operation_i);
  assign w_is_mem   = is_load(w_op) || is_store(w_op);
  assign w_misalign = is_misaligned(w_op, addr_i[1:0]);
  // The instruction that just retired (or faulted) is still on EX-MEM this cycle; never re-issue it.
  assign w_retiring = r_wb_valid || r_bus_err;
  assign w_start    = !rst_i && (r_state == IDLE) && valid_i && w_is_mem && !w_misalign && !w_retiring;

  assign w_cnt_expired = (r_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  kamus_lsu_align u_align (
    .i_st_op      (w_op),
    .i_st_addr_lo (addr_i[1:0]),
    .i_st_wdata   (wdata_i),
    .i_ld_op      (r_op),
    .i_ld_addr_lo (r_addr_lo),
    .i_ld_rdata   (l1d_rdata_i),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_ld_data    (w_ld_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_acc   = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt = REQ;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      REQ: begin
        if (l1d_gnt_i) begin
          w_state_nxt = RSP;
          w_gnt_acc   = 1'b1;
        end else if (w_cnt_expired) begin
          w_state_nxt = IDLE;
          w_timeout   = 1'b1;
        end else begin
          w_state_nxt = REQ;
        end
      end
      RSP: begin
        if (l1d_rvalid_i) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end else if (w_cnt_expired) begin
          w_state_nxt = IDLE;
          w_timeout   = 1'b1;
        end else begin
          w_state_nxt = RSP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_op       <= OP_NOP;
      r_addr_lo  <= 2'b00;
      r_rd       <= 5'd0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 32'h0000_0000;
      r_be       <= 4'b0000;
      r_wdata    <= 32'h0000_0000;
      r_wb_valid <= 1'b0;
      r_wb_data  <= 32'h0000_0000;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_req      <= (w_state_nxt == REQ);
      r_wb_valid <= w_done;
      r_bus_err  <= w_timeout;
      r_wb_data  <= (w_done && is_load(r_op)) ? w_ld_data : 32'h0000_0000;
      if (w_start || w_gnt_acc || (r_state == IDLE)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + TO_W'(1);
      end
      // Capture the access once; EX-MEM changes after this are ignored until we return to IDLE.
      if (w_start) begin
        r_op      <= w_op;
        r_addr_lo <= addr_i[1:0];
        r_rd      <= rd_addr_i;
        r_we      <= is_store(w_op);
        r_addr    <= {addr_i[31:2], 2'b00};
        r_be      <= w_be;
        r_wdata   <= w_wdata;
      end else begin
        r_op      <= r_op;
        r_addr_lo <= r_addr_lo;
        r_rd      <= r_rd;
        r_we      <= r_we;
        r_addr    <= r_addr;
        r_be      <= r_be;
        r_wdata   <= r_wdata;
      end
    end
  end

  assign stall_o        = !rst_i && (w_start || (r_state != IDLE));
  assign exc_misalign_o = !rst_i && (r_state == IDLE) && valid_i && w_is_mem && w_misalign && !w_retiring;
  assign l1d_req_o      = r_req;
  assign l1d_we_o       = r_we;
  assign l1d_addr_o     = r_addr;
  assign l1d_be_o       = r_be;
  assign l1d_wdata_o    = r_wdata;
  assign wb_valid_o     = r_wb_valid;
  assign wb_data_o      = r_wb_data;
  assign wb_rd_addr_o   = r_rd;
  assign exc_bus_err_o  = r_bus_err;

endmodule
